// File: rtl/ps2_rx_controller.sv
// PS/2 device-to-host frame receiver running entirely on the system clock.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       shift_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    state_t                 state_r;
    logic [2:0]             bit_cnt_r;
    logic [TW-1:0]          tmo_cnt_r;
    logic [7:0]             sr_r;
    logic                   parity_r;
    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;

    logic fall_s;
    logic data_s;
    logic timeout_s;
    logic consume_s;
    logic parity_ok_s;
    logic frame_good_s;
    logic load_ok_s;

    // Synchronizers idle high so a reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s       = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign data_s       = data_sync_r[SYNC_STAGES-1];
    assign timeout_s    = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TW'(TIMEOUT_CYCLES));
    assign consume_s    = data_valid & data_ready;
    assign parity_ok_s  = odd_parity_ok(sr_r, parity_r);
    assign frame_good_s = data_s && (!PARITY_EN || parity_ok_s);
    assign load_ok_s    = !data_valid || data_ready;

    // Frame sequencer, timeout supervision and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            tmo_cnt_r  <= {TW{1'b0}};
            sr_r       <= 8'd0;
            parity_r   <= 1'b0;
            shift_en   <= 1'b0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            shift_en  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (consume_s) begin
                data_valid <= 1'b0;
            end
            if ((state_r == ST_IDLE) || fall_s || timeout_s) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end

            if (timeout_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 3'd0;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end else if (fall_s) begin
                case (state_r)
                    ST_IDLE: begin
                        // A high start bit is line noise, not a frame error.
                        if (!data_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                            busy      <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        sr_r      <= {data_s, sr_r[7:1]};
                        shift_en  <= 1'b1;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_r <= data_s;
                        state_r  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        if (frame_good_s) begin
                            if (load_ok_s) begin
                                data_out   <= sr_r;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= 3'd0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Randomized bench for ps2_rx_controller against a frame-level reference model.
module tb_ps2_rx_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       data_ready;
    logic       shift_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_shift  = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int half     = 12;

    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    logic       m_valid;
    logic [7:0] m_data;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ps2_rx_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .shift_en   (shift_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Observe pulses and accepted bytes away from the active edge.
    always @(negedge clk) begin
        if (shift_en)  n_shift <= n_shift + 1;
        if (frame_err) n_ferr  <= n_ferr + 1;
        if (overrun)   n_ovr   <= n_ovr + 1;
        if (data_valid && data_ready) acc_q.push_back(data_out);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Device side: data changes while the clock is high, host samples on the fall.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cycles(half);
            ps2_clk = 1'b0;
            wait_cycles(half);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic check_accepted();
        check_eq("accepted_count", acc_q.size(), exp_q.size());
        while (acc_q.size() > 0 && exp_q.size() > 0) begin
            check_eq("accepted_byte", acc_q.pop_front(), exp_q.pop_front());
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame(input logic [7:0] b, input logic p, input logic stop, input logic rdy);
        int   s0, e0, o0;
        logic good, exp_err, exp_ovr;
        data_ready = rdy;
        if (rdy && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
        s0 = n_shift; e0 = n_ferr; o0 = n_ovr;
        send_bits({stop, p, b, 1'b0}, 11);
        wait_cycles(8);
        good    = stop && (!PAR_EN || ((^b) ^ p));
        exp_err = !good;
        exp_ovr = 1'b0;
        if (good) begin
            if (!m_valid || rdy) begin
                m_data = b;
                if (rdy) exp_q.push_back(b);
                else     m_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        check_eq("shift_en_count", n_shift - s0, 8);
        check_eq("frame_err_count", n_ferr - e0, {31'd0, exp_err});
        check_eq("overrun_count", n_ovr - o0, {31'd0, exp_ovr});
        check_eq("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
        check_eq("data_out", {24'd0, data_out}, {24'd0, m_data});
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
        check_accepted();
    endtask

    initial begin
        int         s0, e0;
        logic [7:0] rb;
        logic       rp, rs, rr;

        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; data_ready = 1'b0;
        m_valid = 1'b0; m_data = 8'd0;
        wait_cycles(3);
        check_eq("rst_outputs", {26'd0, shift_en, data_out == 8'd0 ? 1'b0 : 1'b1,
                 data_valid, frame_err, overrun, busy}, 32'd0);
        check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(5);

        run_frame(8'h1C, 1'b0, 1'b1, 1'b1);

        // Held byte, then overrun, then release by raising ready.
        run_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        run_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        data_ready = 1'b1;
        exp_q.push_back(m_data);
        m_valid = 1'b0;
        wait_cycles(1);
        check_eq("valid_clear_after_accept", {31'd0, data_valid}, 32'd0);
        wait_cycles(2);
        check_accepted();

        run_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        run_frame(8'h1C, 1'b1, 1'b1, 1'b1);

        // Abandoned frame: start plus four data bits, then silence.
        data_ready = 1'b1;
        s0 = n_shift; e0 = n_ferr;
        send_bits({2'b11, 8'hA5, 1'b0}, 5);
        wait_cycles(10);
        check_eq("busy_mid_frame", {31'd0, busy}, 32'd1);
        check_eq("partial_shift_count", n_shift - s0, 4);
        wait_cycles(5100);
        check_eq("timeout_frame_err", n_ferr - e0, 1);
        check_eq("timeout_busy", {31'd0, busy}, 32'd0);
        run_frame(8'h5A, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of a frame with a byte still pending.
        run_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        data_ready = 1'b0;
        send_bits({2'b11, 8'h29, 1'b0}, 4);
        wait_cycles(4);
        check_eq("busy_before_reset", {31'd0, busy}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, data_valid}, 32'd0);
        check_eq("midrst_data_out", {24'd0, data_out}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_pulses", {29'd0, shift_en, frame_err, overrun}, 32'd0);
        m_valid = 1'b0; m_data = 8'd0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        run_frame(8'h29, 1'b0, 1'b1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            rb   = 8'($urandom);
            rp   = ~^rb;
            if ($urandom_range(0, 7) == 0) rp = ~rp;
            rs   = ($urandom_range(0, 7) != 0);
            rr   = 1'($urandom_range(0, 1));
            half = $urandom_range(6, 20);
            run_frame(rb, rp, rs, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
